// File: rtl/booth_arbiter.sv
// Round-robin arbiter sharing one external Booth multiplier among NREQ requesters.
// Optional WAIT watchdog is compiled in with BOOTH_ARB_TIMEOUT_EN.
module booth_arbiter #(
  parameter int NREQ      = 4,
  parameter int X         = 32,
  parameter int Y         = 32,
  parameter int TO_CYCLES = 64,
  localparam int GW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*X-1:0]   req_multiplicand,
  input  logic [NREQ*Y-1:0]   req_multiplier,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [X+Y-1:0]      rsp_product,
  output logic                rsp_error,
  output logic                mul_load,
  output logic [X-1:0]        mul_M,
  output logic [Y-1:0]        mul_Q,
  input  logic                mul_done,
  input  logic [X+Y-1:0]      mul_P,
  output logic                busy,
  output logic [GW-1:0]       grant_id
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [GW-1:0]  gnt_q, gnt_d;
  logic [GW-1:0]  last_q, last_d;
  logic [X-1:0]   m_q, m_d;
  logic [Y-1:0]   q_q, q_d;
  logic [X+Y-1:0] prod_q, prod_d;
  logic           found;
  logic [GW-1:0]  gsel;
  int             idx;

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  // Scan starts one past the last served requester so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    gsel  = '0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!found && req_valid[GW'(idx)]) begin
        found = 1'b1;
        gsel  = GW'(idx);
      end
    end
  end

  assign req_ready   = (reset_n && state_q == S_IDLE && found) ? (NREQ'(1) << gsel) : '0;
  assign rsp_valid   = (state_q == S_RESP) ? (NREQ'(1) << gnt_q) : '0;
  assign rsp_product = prod_q;
  assign mul_load    = (state_q == S_LOAD);
  assign mul_M       = m_q;
  assign mul_Q       = q_q;
  assign busy        = (state_q != S_IDLE);
  assign grant_id    = gnt_q;
`ifdef BOOTH_ARB_TIMEOUT_EN
  assign rsp_error   = err_q;
`else
  assign rsp_error   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    m_d     = m_q;
    q_d     = q_q;
    prod_d  = prod_q;
`ifdef BOOTH_ARB_TIMEOUT_EN
    err_d   = err_q;
    cnt_d   = (state_q == S_WAIT) ? cnt_q + 1'b1 : '0;
`endif
    case (state_q)
      S_IDLE: if (found) begin
        gnt_d   = gsel;
        m_d     = req_multiplicand[gsel*X +: X];
        q_d     = req_multiplier[gsel*Y +: Y];
        state_d = S_LOAD;
      end
      S_LOAD: state_d = S_WAIT;
      S_WAIT: begin
        if (mul_done) begin
          prod_d  = mul_P;
`ifdef BOOTH_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = S_RESP;
        end
`ifdef BOOTH_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TO_CYCLES - 1)) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
`endif
      end
      S_RESP: if (rsp_ready[gnt_q]) begin
        last_d  = gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      last_q  <= GW'(NREQ - 1);
      m_q     <= '0;
      q_q     <= '0;
      prod_q  <= '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
      err_q   <= 1'b0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      m_q     <= m_d;
      q_q     <= q_d;
      prod_q  <= prod_d;
`ifdef BOOTH_ARB_TIMEOUT_EN
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_booth_arbiter.sv
// Bench for booth_arbiter: behavioural multiplier model, round-robin reference model,
// table-driven rounds, randomized rounds and hand-written reset/timeout sequences.
module tb_booth_arbiter;
  localparam int NREQ = 4, X = 32, Y = 32, TO = 64, W = X + Y;

  logic clk = 1'b0, reset_n = 1'b1;
  logic [NREQ-1:0]   req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [NREQ*X-1:0] req_multiplicand = '0;
  logic [NREQ*Y-1:0] req_multiplier = '0;
  logic [W-1:0]      rsp_product, mul_P = '0;
  logic              rsp_error, mul_load, mul_done = 1'b0, busy;
  logic [X-1:0]      mul_M;
  logic [Y-1:0]      mul_Q;
  logic [$clog2(NREQ)-1:0] grant_id;

  always #5 clk = ~clk;

  booth_arbiter #(.NREQ(NREQ), .X(X), .Y(Y), .TO_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_multiplicand(req_multiplicand), .req_multiplier(req_multiplier),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product),
    .rsp_error(rsp_error), .mul_load(mul_load), .mul_M(mul_M), .mul_Q(mul_Q),
    .mul_done(mul_done), .mul_P(mul_P), .busy(busy), .grant_id(grant_id));

  int n_cmp = 0, n_err = 0;
  int m_last = NREQ - 1;
  logic [X-1:0] opm [NREQ];
  logic [Y-1:0] opq [NREQ];
  logic [W-1:0] last_prod;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] smul(input logic [X-1:0] a, input logic [Y-1:0] b);
    logic signed [W-1:0] sa, sb;
    sa = {{Y{a[X-1]}}, a};
    sb = {{X{b[Y-1]}}, b};
    return sa * sb;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int i);
    return NREQ'(1) << i;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] p, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (p[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  // External multiplier: answers lat cycles after the load pulse, or never when hung.
  int mul_lat = 1;
  bit mul_hang = 1'b0, mpend = 1'b0;
  int mcnt = 0;
  logic [X-1:0] mm;
  logic [Y-1:0] mq;
  always @(negedge clk) begin
    mul_done = 1'b0;
    if (mpend) begin
      mcnt--;
      if (mcnt == 0) begin
        mpend = 1'b0; mul_done = 1'b1; mul_P = smul(mm, mq);
      end
    end
    if (mul_load && !mul_hang) begin
      mpend = 1'b1; mcnt = mul_lat; mm = mul_M; mq = mul_Q;
    end
  end

  task automatic set_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_multiplicand[i*X +: X] = opm[i];
      req_multiplier[i*Y +: Y]   = opq[i];
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    m_last = NREQ - 1;
  endtask

  // Serves every requester in mask; grant order predicted by rr_pick from m_last.
  task automatic run_round(input logic [NREQ-1:0] mask, input int lat, input int hold,
                           input bit rnd, output logic [15:0] order);
    logic [NREQ-1:0] pend, v0;
    logic [W-1:0] p0;
    int eg, t, n;
    bit ok;
    pend = mask; mul_lat = lat; order = 16'hFFFF; rsp_ready = '0;
    if (rnd) for (int i = 0; i < NREQ; i++) begin opm[i] = $urandom; opq[i] = $urandom; end
    set_ops();
    req_valid = pend;
    #1;
    while (pend != 0) begin
      eg = rr_pick(pend, m_last);
      t = 0;
      while (req_ready == 0 && t < 20) begin @(negedge clk); t++; end
      check("grant", req_ready, oh(eg));
      if (req_ready == 0) begin req_valid = '0; return; end
      @(posedge clk); #1;
      pend[eg] = 1'b0; req_valid = pend; order = {order[11:0], 4'(eg)};
      @(negedge clk);
      check("mul_load", mul_load, 1);
      check("mul_M", mul_M, opm[eg]);
      check("mul_Q", mul_Q, opq[eg]);
      check("grant_id", grant_id, eg);
      n = 0;
      while (rsp_valid == 0 && n < lat + 10) begin @(negedge clk); n++; end
      check("rsp_latency", n, lat + 1);
      check("rsp_valid", rsp_valid, oh(eg));
      check("rsp_product", rsp_product, smul(opm[eg], opq[eg]));
      check("rsp_error", rsp_error, 0);
      if (rsp_valid == 0) begin req_valid = '0; return; end
      p0 = rsp_product; v0 = rsp_valid; ok = 1'b1;
      rsp_ready = ~oh(eg);
      repeat (hold) begin
        @(negedge clk);
        if (rsp_valid !== v0 || rsp_product !== p0 || busy !== 1'b1 || req_ready !== '0) ok = 1'b0;
      end
      if (hold > 0) check("hold_stable", ok, 1);
      rsp_ready = oh(eg);
      @(posedge clk); #1 rsp_ready = '0;
      m_last = eg; last_prod = p0;
      @(negedge clk);
      check("idle_after_rsp", {busy, rsp_valid}, 0);
    end
    req_valid = '0;
  endtask

  typedef struct {
    logic [NREQ-1:0] mask;
    int              lat;
    int              hold;
    logic [15:0]     exp_order;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [5];
    logic [15:0] ord;
    int n;
    bit bad;
    tbl[0] = '{4'b1111, 3, 0,  16'h0123};
    tbl[1] = '{4'b1001, 2, 1,  16'hFF03};
    tbl[2] = '{4'b0110, 4, 10, 16'hFF12};
    tbl[3] = '{4'b1011, 1, 2,  16'hF301};
    tbl[4] = '{4'b0101, 5, 0,  16'hFF20};

    #2 reset_n = 1'b0; req_valid = '1;
    #3;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_product", rsp_product, 0);
    check("rst_error", rsp_error, 0);
    check("rst_mul_load", mul_load, 0);
    check("rst_mul_M", mul_M, 0);
    check("rst_mul_Q", mul_Q, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    @(posedge clk); #1 req_valid = '0; reset_n = 1'b1;

    // Single request (7, -3), 33-cycle multiply
    opm[0] = 32'd7; opq[0] = 32'hFFFF_FFFD;
    run_round(4'b0001, 33, 0, 1'b0, ord);
    check("single_grant", ord, 16'hFFF0);
    check("single_product", last_prod, 64'hFFFF_FFFF_FFFF_FFEB);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_round(tbl[i].mask, tbl[i].lat, tbl[i].hold, 1'b1, ord);
      check($sformatf("order_vec%0d", i), ord, tbl[i].exp_order);
    end

    for (int r = 0; r < 8; r++)
      run_round(4'($urandom_range(1, 15)), $urandom_range(1, 8), $urandom_range(0, 3), 1'b1, ord);

    // Reset while waiting on the multiplier; its late answer must be dropped
    mul_lat = 20; opm[2] = $urandom; opq[2] = $urandom; set_ops();
    req_valid = 4'b0100; #1;
    n = 0;
    while (req_ready == 0 && n < 20) begin @(negedge clk); n++; end
    check("wait_rst_grant", req_ready, 4'b0100);
    @(posedge clk); #1 req_valid = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("wait_rst_busy", busy, 0);
    check("wait_rst_mul_M", mul_M, 0);
    check("wait_rst_mul_Q", mul_Q, 0);
    check("wait_rst_grant_id", grant_id, 0);
    check("wait_rst_product", rsp_product, 0);
    check("wait_rst_valid", {mul_load, rsp_valid}, 0);
    @(posedge clk); #1 reset_n = 1'b1; m_last = NREQ - 1;
    bad = 1'b0;
    repeat (30) begin @(negedge clk); if (rsp_valid != 0 || busy) bad = 1'b1; end
    check("late_done_ignored", bad, 0);
    run_round(4'b0101, 2, 0, 1'b1, ord);
    check("grant_after_rst", ord, 16'hFF02);

    // Multiplier never answers; a request raised then dropped meanwhile must not transfer
    mul_hang = 1'b1; opm[0] = $urandom; opq[0] = $urandom; set_ops();
    req_valid = 4'b0001; #1;
    n = 0;
    while (req_ready == 0 && n < 20) begin @(negedge clk); n++; end
    check("hang_grant", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    n = 0; bad = 1'b0;
    while (rsp_valid == 0 && n < TO + 40) begin
      @(negedge clk); n++;
      if (n == 3) req_valid[3] = 1'b1;
      if (n == 6) req_valid[3] = 1'b0;
      if (req_ready != 0) bad = 1'b1;
    end
    check("no_grant_while_busy", bad, 0);
`ifdef BOOTH_ARB_TIMEOUT_EN
    check("to_latency", n, TO + 1);
    check("to_rsp_valid", rsp_valid, 4'b0001);
    check("to_error", rsp_error, 1);
    check("to_product", rsp_product, 0);
    rsp_ready = 4'b0001;
    @(posedge clk); #1 rsp_ready = '0; m_last = 0;
`else
    check("hang_no_rsp", rsp_valid, 0);
    check("hang_busy", busy, 1);
    check("hang_error", rsp_error, 0);
    do_reset();
`endif
    mul_hang = 1'b0;
    bad = 1'b0;
    repeat (5) begin @(negedge clk); if (busy || rsp_valid != 0) bad = 1'b1; end
    check("dropped_req_no_xfer", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/booth_arbiter.md
BOOTH_ARBITER -- requirements
Module: booth_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one Booth multiplier.
REQ-002 SHALL have parameter X, default 32: multiplicand width.
REQ-003 SHALL have parameter Y, default 32: multiplier width.
REQ-004 SHALL have parameter TO_CYCLES, default 64: watchdog limit in cycles (used only when REQ-032 applies).
REQ-005 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port req_valid  in  NREQ  per-requester request.
REQ-008 SHALL have port req_ready  out  NREQ  per-requester accept, at most one bit high.
REQ-009 SHALL have port req_multiplicand  in  NREQ*X  packed operands, requester i at bits [i*X +: X].
REQ-010 SHALL have port req_multiplier  in  NREQ*Y  packed operands, requester i at bits [i*Y +: Y].
REQ-011 SHALL have port rsp_valid  out  NREQ  one-hot response valid.
REQ-012 SHALL have port rsp_ready  in  NREQ  per-requester response accept.
REQ-013 SHALL have port rsp_product  out  X+Y  shared product bus, qualified by rsp_valid.
REQ-014 SHALL have port rsp_error  out  1  timeout flag, qualified by rsp_valid.
REQ-015 SHALL have port mul_load  out  1  one-cycle start pulse to multiplier.
REQ-016 SHALL have port mul_M  out  X  multiplicand to multiplier.
REQ-017 SHALL have port mul_Q  out  Y  multiplier operand to multiplier.
REQ-018 SHALL have port mul_done  in  1  multiplier result-valid pulse.
REQ-019 SHALL have port mul_P  in  X+Y  multiplier product, valid with mul_done.
REQ-020 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-021 SHALL have port grant_id  out  $clog2(NREQ)  index of current owner.

Function
REQ-022 SHALL implement FSM states IDLE, LOAD, WAIT, RESP.
REQ-023 IDLE: when any req_valid is high, SHALL select g by round-robin starting at last_grant+1 modulo NREQ, wrapping NREQ-1 to 0.
REQ-024 IDLE: SHALL drive req_ready[g] high combinationally in the same cycle, register operands of g and grant_id=g, then go to LOAD.
REQ-025 LOAD: SHALL assert mul_load for exactly one cycle with registered operands on mul_M/mul_Q, then go to WAIT.
REQ-026 mul_M/mul_Q SHALL hold stable from LOAD until return to IDLE.
REQ-027 WAIT: on mul_done SHALL capture mul_P unmodified (signed X+Y result), clear rsp_error, and go to RESP; mul_done in any other state SHALL be ignored.
REQ-028 RESP: SHALL hold rsp_valid[g]=1 with a stable product until rsp_ready[g]; on that handshake SHALL set last_grant=g and go to IDLE; rsp_ready of other requesters SHALL be ignored.
REQ-029 Latency: accept at cycle 0, mul_load at cycle 1, rsp_valid one cycle after mul_done; at least one IDLE cycle between transactions.
REQ-030 Requesters not granted SHALL keep req_valid asserted; dropping req_valid before grant SHALL be legal and SHALL cause no transfer.

Reset
REQ-031 On reset_n low, immediately and in any state: FSM=IDLE, req_ready=0, rsp_valid=0, rsp_product=0, rsp_error=0, mul_load=0, mul_M=0, mul_Q=0, busy=0, grant_id=0, last_grant=NREQ-1; an in-flight operation is abandoned and a late mul_done is ignored.

Configuration
REQ-032 With BOOTH_ARB_TIMEOUT_EN defined, a counter cleared on entry to WAIT SHALL, after TO_CYCLES cycles without mul_done, force RESP with rsp_product=0 and rsp_error=1.
REQ-033 Without BOOTH_ARB_TIMEOUT_EN, WAIT SHALL wait indefinitely, rsp_error SHALL be tied 0, and no counter logic SHALL exist.

Verification
REQ-034 Single request: req0 = (7, -3), multiplier model returns after 33 cycles -> mul_load at cycle 1, rsp_valid=4'b0001 with product -21 sign-extended to 64 bits.
REQ-035 All four requesters valid from reset with distinct operands -> grants in order 0,1,2,3, and each rsp_product matches the product of that requester's operands.
REQ-036 After a grant to requester 3, requesters 0 and 3 both request -> next grant is 0 (wrap-around).
REQ-037 rsp_ready[g] held low for 10 cycles -> rsp_valid and product stable; no new grant; busy stays 1.
REQ-038 reset_n pulsed low in WAIT, then mul_done arrives -> all outputs zero, FSM in IDLE, no rsp_valid; next grant goes to requester 0.
REQ-039 With BOOTH_ARB_TIMEOUT_EN and TO_CYCLES=64, model never asserts mul_done -> after 64 WAIT cycles rsp_valid with rsp_error=1 and product 0; without the macro, rsp_valid is never asserted.
